vcve2_dmem_arbiter: RTL and testbench

Parametrised successor to the vector/LSU data-memory port switch. It arbitrates `NumReq` OBI-style requesters (VRF load/store FSMs and the scalar LSU) onto one data-memory port. It supports up to `MaxOutstanding` pipelined transactions and routes each response back through an in-order ownership FIFO. It sits between the vector unit / LSU and the core data-memory interface and replaces the single-previous-master tracking with true multi-outstanding routing, bus locking and selectable arbitration.

---
 rtl/vcve2_dmem_pkg.sv | 29 ++
 rtl/vcve2_dmem_resp_fifo.sv | 68 ++++++
 rtl/vcve2_dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vcve2_dmem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_dmem_pkg.sv
// Shared types and helpers for the vector/LSU data-memory arbiter.
//   vcve2_dmem_req_t  : per-requester request fields muxed onto the memory port
//   vcve2_dmem_rsp_t  : memory response fields broadcast back to requesters
//   lock_state_e      : bus-lock state of the arbiter
//   VCVE2_DMEM_IDX_W  : width of a requester index, never less than 1
package vcve2_dmem_pkg;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vcve2_dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } vcve2_dmem_rsp_t;

  typedef enum logic {
    StUnlocked,
    StLocked
  } lock_state_e;

  function automatic int unsigned VCVE2_DMEM_IDX_W(int unsigned n);
    return (n > 2) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/vcve2_dmem_resp_fifo.sv
// In-order ownership FIFO: records which requester owns each outstanding memory transaction.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i/data_i: enqueue an owner index (ignored when full)
//   pop_i        : dequeue the head (ignored when empty)
//   head_o       : owner of the oldest outstanding transaction
//   full_o, empty_o, count_o : occupancy status
module vcve2_dmem_resp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vcve2_dmem_arbiter.sv
// Arbitrates NumReq OBI-style requesters (VRF load/store FSMs, scalar LSU at NumReq-1) onto one
// data-memory port with up to MaxOutstanding pipelined transactions, in-order response routing,
// bus locking and a sticky winner while a request waits for its grant.
//   req_*   : requester side (grant/rvalid/err one-hot or zero, rdata broadcast)
//   data_*  : memory side
//   spurious_o    : sticky, set by an rvalid with nothing outstanding
//   outstanding_o : current ownership-FIFO occupancy
// Build option: define VCVE2_DMEM_ARB_RR_EN for round-robin; otherwise lowest index wins.
module vcve2_dmem_arbiter
  import vcve2_dmem_pkg::*;
#(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_req_i,
  output logic [NumReq-1:0]                   req_gnt_o,
  output logic [NumReq-1:0]                   req_rvalid_o,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq*4-1:0]                 req_be_i,
  input  logic [NumReq*32-1:0]                req_addr_i,
  input  logic [NumReq*32-1:0]                req_wdata_i,
  output logic [NumReq*32-1:0]                req_rdata_o,
  output logic [NumReq-1:0]                   req_err_o,
  input  logic [NumReq-1:0]                   req_lock_i,
  output logic                                data_req_o,
  output logic                                data_we_o,
  output logic [3:0]                          data_be_o,
  output logic [31:0]                         data_addr_o,
  output logic [31:0]                         data_wdata_o,
  input  logic                                data_gnt_i,
  input  logic                                data_rvalid_i,
  input  logic                                data_err_i,
  input  logic [31:0]                         data_rdata_i,
  output logic                                spurious_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

  localparam int unsigned IdxW = VCVE2_DMEM_IDX_W(NumReq);

  vcve2_dmem_req_t req_fields [NumReq];
  vcve2_dmem_req_t win_fields;
  vcve2_dmem_rsp_t rsp;

  lock_state_e     lock_q, lock_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic            sticky_q, sticky_d;
  logic [IdxW-1:0] sticky_idx_q, sticky_idx_d;
  logic            spurious_q;
`ifdef VCVE2_DMEM_ARB_RR_EN
  logic [IdxW-1:0] rr_q, rr_d;
`endif

  logic              lock_held;
  logic [NumReq-1:0] elig;
  logic              search_valid, win_valid;
  logic [IdxW-1:0]   search_idx, win_idx, head_idx;
  int unsigned       cand;
  logic              fifo_full, fifo_empty, handshake, pop;

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_fields[i] = '{we:    req_we_i[i],
                        be:    req_be_i[i*4 +: 4],
                        addr:  req_addr_i[i*32 +: 32],
                        wdata: req_wdata_i[i*32 +: 32]};
    end
  end

  // An owner releasing its lock in this cycle already opens arbitration in this cycle.
  assign lock_held = (lock_q == StLocked) && req_lock_i[owner_q];

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      elig[i] = req_req_i[i] && (!lock_held || owner_q == IdxW'(i));
    end
  end

  always_comb begin
    search_valid = 1'b0;
    search_idx   = '0;
    cand         = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
`ifdef VCVE2_DMEM_ARB_RR_EN
      cand = (32'(rr_q) + k) % NumReq;
`else
      cand = k;
`endif
      if (!search_valid && elig[cand]) begin
        search_valid = 1'b1;
        search_idx   = IdxW'(cand);
      end
    end
  end

  // A request left waiting on data_gnt_i keeps its slot until the handshake.
  assign win_idx    = sticky_q ? sticky_idx_q : search_idx;
  assign win_valid  = sticky_q ? req_req_i[sticky_idx_q] : search_valid;
  assign win_fields = req_fields[win_idx];

  assign data_req_o   = win_valid && !fifo_full && !rst_i;
  assign data_we_o    = win_fields.we;
  assign data_be_o    = win_fields.be;
  assign data_addr_o  = win_fields.addr;
  assign data_wdata_o = win_fields.wdata;

  assign handshake = data_req_o && data_gnt_i;
  assign pop       = data_rvalid_i && !fifo_empty;
  assign rsp       = '{rdata: data_rdata_i, err: data_err_i};

  always_comb begin
    req_gnt_o    = '0;
    req_rvalid_o = '0;
    req_err_o    = '0;
    if (handshake) req_gnt_o[win_idx] = 1'b1;
    if (pop) begin
      req_rvalid_o[head_idx] = 1'b1;
      req_err_o[head_idx]    = rsp.err;
    end
  end

  assign req_rdata_o = {NumReq{rsp.rdata}};
  assign spurious_o  = spurious_q;

  always_comb begin
    lock_d       = lock_held ? StLocked : StUnlocked;
    owner_d      = owner_q;
    sticky_d     = data_req_o && !data_gnt_i;
    sticky_idx_d = win_idx;
    if (handshake && req_lock_i[win_idx]) begin
      lock_d  = StLocked;
      owner_d = win_idx;
    end
`ifdef VCVE2_DMEM_ARB_RR_EN
    rr_d = rr_q;
    if (handshake) rr_d = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q       <= StUnlocked;
      owner_q      <= '0;
      sticky_q     <= 1'b0;
      sticky_idx_q <= '0;
      spurious_q   <= 1'b0;
`ifdef VCVE2_DMEM_ARB_RR_EN
      rr_q         <= '0;
`endif
    end else begin
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      sticky_q     <= sticky_d;
      sticky_idx_q <= sticky_idx_d;
      spurious_q   <= spurious_q | (data_rvalid_i && fifo_empty);
`ifdef VCVE2_DMEM_ARB_RR_EN
      rr_q         <= rr_d;
`endif
    end
  end

  vcve2_dmem_resp_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (win_idx),
    .pop_i   (pop),
    .head_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_vcve2_dmem_arbiter.sv
module tb_vcve2_dmem_arbiter;
  localparam int N = 3;
  localparam int M = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_req, req_we, req_lock, req_gnt, req_rvalid, req_err;
  logic [N*4-1:0]  req_be;
  logic [N*32-1:0] req_addr, req_wdata, req_rdata;
  logic          data_req, data_we, data_gnt, data_rvalid, data_err, spurious;
  logic [3:0]    data_be;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic [1:0]    outstanding;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  fifo_q[$];
  bit  m_locked, m_sticky, m_spur;
  int  m_owner, m_sticky_idx, m_rr;
  bit  exp_wv, exp_lk, exp_dreq;
  int  exp_w;
  logic [N-1:0] exp_gnt, exp_rvalid, exp_err;

  vcve2_dmem_arbiter #(.NumReq(N), .MaxOutstanding(M)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_req_i(req_req), .req_gnt_o(req_gnt), .req_rvalid_o(req_rvalid),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_rdata_o(req_rdata), .req_err_o(req_err), .req_lock_i(req_lock),
    .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
    .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_err_i(data_err),
    .data_rdata_i(data_rdata), .spurious_o(spurious), .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic model_reset();
    fifo_q.delete();
    m_locked = 0; m_sticky = 0; m_spur = 0;
    m_owner = 0; m_sticky_idx = 0; m_rr = 0;
  endtask

  // Expected combinational outputs from the arbitration rules and current model state.
  task automatic model_eval();
    int c;
    bit lk;
    lk = m_locked && req_lock[m_owner];
    exp_wv = 0; exp_w = 0;
    if (m_sticky) begin
      exp_w = m_sticky_idx; exp_wv = req_req[exp_w];
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!exp_wv && req_req[c] && (!lk || c == m_owner)) begin
          exp_wv = 1; exp_w = c;
        end
      end
    end
    exp_lk = lk;
    exp_dreq = exp_wv && (fifo_q.size() < M) && !rst;
    exp_gnt = '0;
    if (exp_dreq && data_gnt) exp_gnt[exp_w] = 1'b1;
    exp_rvalid = '0; exp_err = '0;
    if (data_rvalid && fifo_q.size() > 0 && !rst) begin
      exp_rvalid[fifo_q[0]] = 1'b1;
      exp_err[fifo_q[0]] = data_err;
    end
  endtask

  task automatic model_update();
    bit hs;
    if (rst) begin model_reset(); return; end
    hs = exp_dreq && data_gnt;
    if (data_rvalid) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      else m_spur = 1;
    end
    if (hs) fifo_q.push_back(exp_w);
    m_locked = exp_lk;
    if (hs && req_lock[exp_w]) begin m_locked = 1; m_owner = exp_w; end
    m_sticky = exp_dreq && !data_gnt;
    m_sticky_idx = exp_w;
`ifdef VCVE2_DMEM_ARB_RR_EN
    if (hs) m_rr = (exp_w + 1) % N;
`endif
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_req[i] = 1'b1;
    req_we[i] = we;
    req_be[i*4 +: 4] = be;
    req_addr[i*32 +: 32] = addr;
    req_wdata[i*32 +: 32] = wdata;
  endtask

  task automatic clear_inputs();
    req_req = '0; req_we = '0; req_lock = '0; req_be = '0; req_addr = '0; req_wdata = '0;
    data_gnt = 0; data_rvalid = 0; data_err = 0; data_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    req_req = 3'b111; data_gnt = 1; data_rvalid = 1;
    settle();
    checks += 5;
    if (data_req !== 1'b0) begin errors++; $display("FAIL reset_dreq got %b need 0", data_req); end
    if (req_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b need 000", req_gnt); end
    if (req_rvalid !== 3'b000) begin
      errors++; $display("FAIL reset_rvalid got %b need 000", req_rvalid);
    end
    if (outstanding !== 2'd0) begin
      errors++; $display("FAIL reset_outstanding got %0d need 0", outstanding);
    end
    if (spurious !== 1'b0) begin errors++; $display("FAIL reset_spurious got %b need 0", spurious); end
    tick();
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_contend();
    int seq[4];
`ifdef VCVE2_DMEM_ARB_RR_EN
    seq[0] = 0; seq[1] = 2; seq[2] = 0; seq[3] = 2;
`else
    seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 0;
`endif
    do_reset();
    set_req(0, 1'b0, 4'hf, 32'h1000, 32'h0);
    set_req(2, 1'b1, 4'h3, 32'h2000, 32'h55);
    data_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      data_rvalid = (fifo_q.size() > 0);
      settle();
      checks++;
      if (req_gnt !== N'(1 << seq[k])) begin
        errors++; $display("FAIL contend_gnt%0d got %b need %b", k, req_gnt, N'(1 << seq[k]));
      end
      tick();
    end
    clear_inputs();
    data_rvalid = 1;
    tick();
    data_rvalid = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_gnt = 1;
    set_req(1, 1'b0, 4'hf, 32'h100, 32'h0);
    settle(); checks++;
    if (req_gnt !== 3'b010) begin errors++; $display("FAIL b2b_gnt1 got %b need 010", req_gnt); end
    tick(); req_req = '0;
    set_req(0, 1'b0, 4'hf, 32'h200, 32'h0);
    settle(); checks++;
    if (req_gnt !== 3'b001) begin errors++; $display("FAIL b2b_gnt0 got %b need 001", req_gnt); end
    tick(); req_req = '0;
    set_req(1, 1'b0, 4'hf, 32'h104, 32'h0);
    settle(); checks += 2;
    if (data_req !== 1'b0) begin errors++; $display("FAIL b2b_full_dreq got %b need 0", data_req); end
    if (outstanding !== 2'd2) begin
      errors++; $display("FAIL b2b_outstanding got %0d need 2", outstanding);
    end
    tick();
    data_rvalid = 1; data_rdata = 32'hA5A5_0001;
    settle(); checks += 3;
    if (req_rvalid !== 3'b010) begin
      errors++; $display("FAIL b2b_rvalid1 got %b need 010", req_rvalid);
    end
    if (req_rdata[32 +: 32] !== 32'hA5A5_0001) begin
      errors++; $display("FAIL b2b_rdata1 got %h need a5a50001", req_rdata[32 +: 32]);
    end
    if (data_req !== 1'b0) begin errors++; $display("FAIL b2b_nobypass got %b need 0", data_req); end
    tick();
    data_rvalid = 0;
    settle(); checks++;
    if (req_gnt !== 3'b010) begin errors++; $display("FAIL b2b_gnt3 got %b need 010", req_gnt); end
    tick(); req_req = '0;
    data_rvalid = 1; data_rdata = 32'hA5A5_0002;
    settle(); checks += 2;
    if (req_rvalid !== 3'b001) begin
      errors++; $display("FAIL b2b_rvalid2 got %b need 001", req_rvalid);
    end
    if (req_rdata[0 +: 32] !== 32'hA5A5_0002) begin
      errors++; $display("FAIL b2b_rdata2 got %h need a5a50002", req_rdata[0 +: 32]);
    end
    tick();
    data_rdata = 32'hA5A5_0003;
    settle(); checks += 2;
    if (req_rvalid !== 3'b010) begin
      errors++; $display("FAIL b2b_rvalid3 got %b need 010", req_rvalid);
    end
    if (req_rdata[32 +: 32] !== 32'hA5A5_0003) begin
      errors++; $display("FAIL b2b_rdata3 got %h need a5a50003", req_rdata[32 +: 32]);
    end
    tick();
    data_rvalid = 0;
  endtask

  task automatic test_lock();
    do_reset();
    data_gnt = 1;
    set_req(2, 1'b1, 4'hf, 32'h300, 32'h77);
    req_lock[2] = 1;
    settle(); checks++;
    if (req_gnt !== 3'b100) begin errors++; $display("FAIL lock_gnt2 got %b need 100", req_gnt); end
    tick();
    req_req[2] = 0;
    set_req(0, 1'b0, 4'hf, 32'h400, 32'h0);
    data_rvalid = 1;
    for (int k = 0; k < 3; k++) begin
      settle(); checks++;
      if (req_gnt !== 3'b000) begin
        errors++; $display("FAIL lock_hold%0d got %b need 000", k, req_gnt);
      end
      tick();
      data_rvalid = 0;
    end
    req_lock[2] = 0;
    settle(); checks++;
    if (req_gnt !== 3'b001) begin errors++; $display("FAIL lock_release got %b need 001", req_gnt); end
    tick();
    clear_inputs();
    data_rvalid = 1;
    tick();
    data_rvalid = 0;
  endtask

  task automatic test_stall();
    do_reset();
    set_req(1, 1'b0, 4'hf, 32'h111, 32'h0);
    for (int k = 0; k < 3; k++) begin
      settle(); checks += 3;
      if (data_req !== 1'b1) begin errors++; $display("FAIL stall_dreq%0d got %b need 1", k, data_req); end
      if (data_addr !== 32'h111) begin
        errors++; $display("FAIL stall_addr%0d got %h need 00000111", k, data_addr);
      end
      if (req_gnt !== 3'b000) begin
        errors++; $display("FAIL stall_gnt%0d got %b need 000", k, req_gnt);
      end
      tick();
      if (k == 0) set_req(0, 1'b1, 4'h1, 32'h222, 32'h9);
    end
    data_gnt = 1;
    settle(); checks++;
    if (req_gnt !== 3'b010) begin errors++; $display("FAIL stall_gnt got %b need 010", req_gnt); end
    tick();
    clear_inputs();
    data_rvalid = 1;
    tick();
    data_rvalid = 0;
  endtask

  task automatic test_spurious();
    do_reset();
    data_rvalid = 1; data_err = 1;
    settle(); checks += 2;
    if (req_rvalid !== 3'b000) begin
      errors++; $display("FAIL spur_rvalid got %b need 000", req_rvalid);
    end
    if (req_err !== 3'b000) begin errors++; $display("FAIL spur_err got %b need 000", req_err); end
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      settle(); checks++;
      if (spurious !== 1'b1) begin errors++; $display("FAIL spur_flag%0d got %b need 1", k, spurious); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_gnt = 1;
    set_req(0, 1'b0, 4'hf, 32'h10, 32'h0);
    tick();
    req_req = '0;
    set_req(1, 1'b0, 4'hf, 32'h20, 32'h0);
    tick();
    req_req = '0;
    settle(); checks++;
    if (outstanding !== 2'd2) begin
      errors++; $display("FAIL rstmid_before got %0d need 2", outstanding);
    end
    tick();
    do_reset();
    settle(); checks += 2;
    if (outstanding !== 2'd0) begin
      errors++; $display("FAIL rstmid_after got %0d need 0", outstanding);
    end
    if (spurious !== 1'b0) begin errors++; $display("FAIL rstmid_spur0 got %b need 0", spurious); end
    tick();
    data_rvalid = 1;
    settle(); checks++;
    if (req_rvalid !== 3'b000) begin
      errors++; $display("FAIL rstmid_rvalid got %b need 000", req_rvalid);
    end
    tick();
    data_rvalid = 0;
    settle(); checks++;
    if (spurious !== 1'b1) begin errors++; $display("FAIL rstmid_spur1 got %b need 1", spurious); end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] last_gnt;
    do_reset();
    last_gnt = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i]) req_req[i] = 1'b0;
        if (!req_req[i] && ($urandom % 3 == 0))
          set_req(i, 1'($urandom), 4'($urandom), $urandom, $urandom);
        req_lock[i] = ($urandom % 4 == 0);
      end
      data_gnt = ($urandom % 3 != 0);
      data_rvalid = (fifo_q.size() > 0) && ($urandom % 2 == 0);
      data_rdata = $urandom;
      data_err = 1'($urandom);
      settle();
      checks += 6;
      if (data_req !== exp_dreq) begin
        errors++; $display("FAIL rnd_dreq c%0d got %b need %b", cyc, data_req, exp_dreq);
      end
      if (req_gnt !== exp_gnt) begin
        errors++; $display("FAIL rnd_gnt c%0d got %b need %b", cyc, req_gnt, exp_gnt);
      end
      if (req_rvalid !== exp_rvalid) begin
        errors++; $display("FAIL rnd_rvalid c%0d got %b need %b", cyc, req_rvalid, exp_rvalid);
      end
      if (req_err !== exp_err) begin
        errors++; $display("FAIL rnd_err c%0d got %b need %b", cyc, req_err, exp_err);
      end
      if (outstanding !== 2'(fifo_q.size())) begin
        errors++; $display("FAIL rnd_outst c%0d got %0d need %0d", cyc, outstanding, fifo_q.size());
      end
      if (spurious !== m_spur) begin
        errors++; $display("FAIL rnd_spur c%0d got %b need %b", cyc, spurious, m_spur);
      end
      if (exp_dreq) begin
        checks++;
        if ({data_we, data_be, data_addr, data_wdata} !==
            {req_we[exp_w], req_be[exp_w*4 +: 4], req_addr[exp_w*32 +: 32],
             req_wdata[exp_w*32 +: 32]}) begin
          errors++;
          $display("FAIL rnd_fields c%0d got %b %h %h %h need req %0d", cyc, data_we, data_be,
                   data_addr, data_wdata, exp_w);
        end
      end
      if (exp_rvalid != '0) begin
        checks++;
        if (req_rdata[fifo_q[0]*32 +: 32] !== data_rdata) begin
          errors++;
          $display("FAIL rnd_rdata c%0d got %h need %h", cyc, req_rdata[fifo_q[0]*32 +: 32],
                   data_rdata);
        end
      end
      last_gnt = exp_gnt;
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_contend();
    test_back_to_back();
    test_lock();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
